// File: rtl/acc_drain_if.sv
// rtl/acc_drain_if.sv - capture and result-stream signals of the accumulator drain stage
interface acc_drain_if #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 9,
  parameter int ACC_WIDTH  = 17,
  parameter int SHIFT_W    = 5
) ();
  logic                      capture_i;
  logic [N*ACC_WIDTH-1:0]    acc_i;
  logic [SHIFT_W-1:0]        shift_i;
  logic                      relu_en_i;
  logic                      out_ready_i;
  logic                      out_valid_o;
  logic [DATA_WIDTH-1:0]     out_data_o;
  logic [$clog2(N)-1:0]      out_idx_o;
  logic                      out_last_o;
  logic                      busy_o;
  logic                      overrun_o;

  modport master (
    output capture_i, acc_i, shift_i, relu_en_i, out_ready_i,
    input  out_valid_o, out_data_o, out_idx_o, out_last_o, busy_o, overrun_o
  );

  modport slave (
    input  capture_i, acc_i, shift_i, relu_en_i, out_ready_i,
    output out_valid_o, out_data_o, out_idx_o, out_last_o, busy_o, overrun_o
  );
endinterface

// File: rtl/acc_drain.sv
// rtl/acc_drain.sv - capture a MAC row, requantize (ReLU, round, saturate) and stream it out
module acc_drain #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 9,
  parameter int ACC_WIDTH  = 17,
  parameter int SHIFT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  acc_drain_if.slave  bus
);
  localparam int IDX_W = $clog2(N);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((2 ** (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                 state;
  logic [N*ACC_WIDTH-1:0] buf_acc;
  logic [SHIFT_W-1:0]     buf_shift;
  logic                   buf_relu;
  logic [IDX_W-1:0]       idx;
  logic                   valid;
  logic                   busy;
  logic                   last;
  logic                   overrun;

  logic fire;
  logic final_hs;
  logic accept;

  assign fire     = valid && bus.out_ready_i;
  assign final_hs = fire && (idx == IDX_W'(N-1));
  // A new row may land on the last handshake so back-to-back drains have no bubble.
  assign accept   = bus.capture_i && ((state == IDLE) || final_hs);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      buf_acc   <= '0;
      buf_shift <= '0;
      buf_relu  <= 1'b0;
      idx       <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      last      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        state     <= DRAIN;
        buf_acc   <= bus.acc_i;
        buf_shift <= bus.shift_i;
        buf_relu  <= bus.relu_en_i;
        idx       <= '0;
        valid     <= 1'b1;
        busy      <= 1'b1;
        last      <= (N == 1);
      end else if (final_hs) begin
        state <= IDLE;
        idx   <= '0;
        valid <= 1'b0;
        busy  <= 1'b0;
        last  <= 1'b0;
      end else if (fire) begin
        idx  <= idx + 1'b1;
        last <= ((idx + 1'b1) == IDX_W'(N-1));
      end
      if (bus.capture_i && !accept)
        overrun <= 1'b1;
    end
  end

  logic [ACC_WIDTH-1:0]      lane;
  logic signed [ACC_WIDTH:0] x;
  logic signed [ACC_WIDTH:0] rnd;
  logic signed [ACC_WIDTH:0] y;
  logic [DATA_WIDTH-1:0]     sat;
  int                        s_amt;

  // Sum is one bit wider than the accumulator so the rounding add cannot wrap.
  always_comb begin
    lane  = buf_acc[int'(idx)*ACC_WIDTH +: ACC_WIDTH];
    x     = {lane[ACC_WIDTH-1], lane};
    if (buf_relu && x[ACC_WIDTH])
      x = '0;
    s_amt = (int'(buf_shift) > ACC_WIDTH-1) ? ACC_WIDTH-1 : int'(buf_shift);
    rnd   = '0;
    if (s_amt > 0)
      rnd = (ACC_WIDTH+1)'(1) << (s_amt - 1);
    y     = (x + rnd) >>> s_amt;
    if (y > SAT_MAX)
      sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (y < SAT_MIN)
      sat = SAT_MIN[DATA_WIDTH-1:0];
    else
      sat = y[DATA_WIDTH-1:0];
  end

  assign bus.out_valid_o = valid;
  assign bus.out_data_o  = valid ? sat : '0;
  assign bus.out_idx_o   = idx;
  assign bus.out_last_o  = last;
  assign bus.busy_o      = busy;
  assign bus.overrun_o   = overrun;
endmodule

// File: tb/tb_acc_drain.sv
// tb/tb_acc_drain.sv - randomized and directed checks of acc_drain against an arithmetic model
module tb_acc_drain;
  localparam int N  = 4;
  localparam int DW = 9;
  localparam int AW = 17;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acc_drain_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SHIFT_W(SW)) bus ();

  acc_drain #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SHIFT_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int lanes[N];
  int cur_shift;
  bit cur_relu;

  // Requantization from first principles: floor division by 2^s after adding half.
  function automatic int model_elem(int xin, int sh, bit relu);
    longint v, d, num, q;
    int s;
    v = xin;
    if (relu && v < 0) v = 0;
    s = (sh > AW-1) ? AW-1 : sh;
    if (s > 0) begin
      d   = longint'(1) << s;
      num = v + d / 2;
      q   = num / d;
      if ((num % d != 0) && (num < 0)) q = q - 1;
      v   = q;
    end
    if (v > (2 ** (DW-1)) - 1) v = (2 ** (DW-1)) - 1;
    if (v < -(2 ** (DW-1))) v = -(2 ** (DW-1));
    return int'(v);
  endfunction

  function automatic int rand_lane();
    if ($urandom_range(0, 1) == 1)
      return int'($urandom_range(0, 2000)) - 1000;
    return int'($urandom_range(0, (2 ** AW) - 1)) - (2 ** (AW-1));
  endfunction

  task automatic set_inputs();
    for (int k = 0; k < N; k++)
      bus.acc_i[k*AW +: AW] = AW'(lanes[k]);
    bus.shift_i   = SW'(cur_shift);
    bus.relu_en_i = cur_relu;
  endtask

  function automatic int got_data();
    return int'($signed(bus.out_data_o));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.capture_i   = 1'b1;
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < N; k++) lanes[k] = rand_lane();
    cur_shift = 0; cur_relu = 1'b0;
    set_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", bus.out_valid_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy_o); end
    checks++; if (bus.overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b exp 0", bus.overrun_o); end
    checks++; if (bus.out_data_o !== '0) begin errors++; $display("FAIL reset_data got %0d exp 0", got_data()); end
    checks++; if (bus.out_idx_o !== '0 || bus.out_last_o !== 1'b0) begin errors++; $display("FAIL reset_idx_last got %0d/%0b exp 0/0", bus.out_idx_o, bus.out_last_o); end
    rst = 1'b0;
    bus.capture_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_no_capture got valid %0b exp 0", bus.out_valid_o); end
  endtask

  task automatic test_basic_drain();
    int exp_d[N] = '{100, -50, 255, -256};
    lanes = '{100, -50, 300, -1000};
    cur_shift = 0; cur_relu = 1'b0;
    set_inputs();
    bus.capture_i = 1'b1; bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.capture_i = 1'b0;
    for (int k = 0; k < N; k++) begin
      checks++; if (bus.out_valid_o !== 1'b1 || bus.busy_o !== 1'b1) begin errors++; $display("FAIL basic_valid k=%0d got %0b/%0b exp 1/1", k, bus.out_valid_o, bus.busy_o); end
      checks++; if (int'(bus.out_idx_o) !== k) begin errors++; $display("FAIL basic_idx got %0d exp %0d", bus.out_idx_o, k); end
      checks++; if (got_data() !== exp_d[k]) begin errors++; $display("FAIL basic_data k=%0d got %0d exp %0d", k, got_data(), exp_d[k]); end
      checks++; if (bus.out_last_o !== (k == N-1)) begin errors++; $display("FAIL basic_last k=%0d got %0b", k, bus.out_last_o); end
      @(negedge clk);
    end
    checks++; if (bus.busy_o !== 1'b0 || bus.out_valid_o !== 1'b0 || bus.out_data_o !== '0) begin errors++; $display("FAIL basic_end got busy %0b valid %0b data %0d exp 0/0/0", bus.busy_o, bus.out_valid_o, got_data()); end
  endtask

  task automatic test_relu_shift();
    int exp_d[N] = '{2, 0, 255, 2};
    lanes = '{7, -8, 1023, 6};
    cur_shift = 2; cur_relu = 1'b1;
    set_inputs();
    bus.capture_i = 1'b1; bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.capture_i = 1'b0;
    for (int k = 0; k < N; k++) begin
      checks++; if (got_data() !== exp_d[k] || bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL relu_shift k=%0d got %0d valid %0b exp %0d", k, got_data(), bus.out_valid_o, exp_d[k]); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int cycles = 0;
    int stalls = 0;
    bit done = 1'b0;
    lanes = '{100, -50, 300, -1000};
    cur_shift = 0; cur_relu = 1'b0;
    set_inputs();
    bus.capture_i = 1'b1; bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.capture_i = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid cycle %0d got %0b exp 1", c, bus.out_valid_o); end
      cycles++;
      if (bus.out_idx_o == 1) begin
        checks++; if (got_data() !== -50) begin errors++; $display("FAIL bp_hold_data got %0d exp -50", got_data()); end
      end
      if (bus.out_idx_o == 1 && stalls < 3) begin
        bus.out_ready_i = 1'b0;
        stalls++;
      end else begin
        bus.out_ready_i = 1'b1;
        if (bus.out_last_o) done = 1'b1;
      end
      @(negedge clk);
    end
    bus.out_ready_i = 1'b1;
    checks++; if (cycles !== 7 || !done) begin errors++; $display("FAIL bp_cycles got %0d exp 7", cycles); end
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_end_valid got %0b exp 0", bus.out_valid_o); end
  endtask

  task automatic test_overrun_back_to_back();
    int exp_c[N];
    lanes = '{100, -50, 300, -1000};
    cur_shift = 0; cur_relu = 1'b0;
    set_inputs();
    bus.capture_i = 1'b1; bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.capture_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_idx_o !== 2'd1) begin errors++; $display("FAIL ovr_idx1 got %0d exp 1", bus.out_idx_o); end
    for (int k = 0; k < N; k++) lanes[k] = rand_lane();
    set_inputs();
    bus.capture_i = 1'b1;
    @(negedge clk);
    bus.capture_i = 1'b0;
    checks++; if (bus.overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_flag got %0b exp 1", bus.overrun_o); end
    checks++; if (bus.out_idx_o !== 2'd2 || got_data() !== 255) begin errors++; $display("FAIL ovr_orig_data got idx %0d data %0d exp 2/255", bus.out_idx_o, got_data()); end
    @(negedge clk);
    checks++; if (got_data() !== -256 || bus.out_last_o !== 1'b1) begin errors++; $display("FAIL ovr_last got data %0d last %0b exp -256/1", got_data(), bus.out_last_o); end
    for (int k = 0; k < N; k++) begin
      lanes[k] = rand_lane();
      exp_c[k] = model_elem(lanes[k], 3, 1'b0);
    end
    cur_shift = 3;
    set_inputs();
    bus.capture_i = 1'b1;
    @(negedge clk);
    bus.capture_i = 1'b0;
    for (int k = 0; k < N; k++) begin
      checks++; if (bus.out_valid_o !== 1'b1 || int'(bus.out_idx_o) !== k || got_data() !== exp_c[k]) begin errors++; $display("FAIL b2b_data k=%0d got valid %0b idx %0d data %0d exp %0d", k, bus.out_valid_o, bus.out_idx_o, got_data(), exp_c[k]); end
      @(negedge clk);
    end
    checks++; if (bus.out_valid_o !== 1'b0 || bus.overrun_o !== 1'b1) begin errors++; $display("FAIL b2b_end got valid %0b overrun %0b exp 0/1", bus.out_valid_o, bus.overrun_o); end
  endtask

  task automatic test_clamp_reset();
    int exp_d[N];
    lanes[0] = 65535;
    for (int k = 1; k < N; k++) lanes[k] = rand_lane();
    cur_shift = 31; cur_relu = 1'b0;
    for (int k = 0; k < N; k++) exp_d[k] = model_elem(lanes[k], cur_shift, cur_relu);
    set_inputs();
    bus.capture_i = 1'b1; bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.capture_i = 1'b0;
    checks++; if (got_data() !== 1) begin errors++; $display("FAIL clamp_lane0 got %0d exp 1", got_data()); end
    @(negedge clk);
    checks++; if (got_data() !== exp_d[1]) begin errors++; $display("FAIL clamp_lane1 got %0d exp %0d", got_data(), exp_d[1]); end
    @(negedge clk);
    checks++; if (bus.out_idx_o !== 2'd2) begin errors++; $display("FAIL mid_idx got %0d exp 2", bus.out_idx_o); end
    rst = 1'b1;
    bus.capture_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.capture_i = 1'b0;
    checks++; if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.overrun_o !== 1'b0 || bus.out_data_o !== '0 || bus.out_idx_o !== '0) begin errors++; $display("FAIL mid_reset got valid %0b busy %0b overrun %0b data %0d idx %0d exp all 0", bus.out_valid_o, bus.busy_o, bus.overrun_o, got_data(), bus.out_idx_o); end
    for (int k = 0; k < N; k++) begin
      lanes[k] = rand_lane();
      exp_d[k] = model_elem(lanes[k], 5, 1'b1);
    end
    cur_shift = 5; cur_relu = 1'b1;
    set_inputs();
    bus.capture_i = 1'b1;
    @(negedge clk);
    bus.capture_i = 1'b0;
    for (int k = 0; k < N; k++) begin
      checks++; if (int'(bus.out_idx_o) !== k || got_data() !== exp_d[k]) begin errors++; $display("FAIL post_reset k=%0d got idx %0d data %0d exp %0d", k, bus.out_idx_o, got_data(), exp_d[k]); end
      @(negedge clk);
    end
  endtask

  task automatic load_random(output int exp_d[N]);
    for (int k = 0; k < N; k++) lanes[k] = rand_lane();
    cur_shift = int'($urandom_range(0, 31));
    cur_relu  = 1'(($urandom_range(0, 1)));
    for (int k = 0; k < N; k++) exp_d[k] = model_elem(lanes[k], cur_shift, cur_relu);
    set_inputs();
  endtask

  task automatic test_random();
    int exp_d[N];
    int exp_idx = 0;
    int drains = 0;
    bit idle_next;
    load_random(exp_d);
    bus.capture_i = 1'b1;
    @(negedge clk);
    bus.capture_i = 1'b0;
    for (int c = 0; c < 3000 && drains < 30; c++) begin
      idle_next = 1'b0;
      checks++; if (bus.out_valid_o !== 1'b1 || int'(bus.out_idx_o) !== exp_idx) begin errors++; $display("FAIL rnd_idx got valid %0b idx %0d exp 1/%0d", bus.out_valid_o, bus.out_idx_o, exp_idx); end
      checks++; if (got_data() !== exp_d[exp_idx] || bus.out_last_o !== (exp_idx == N-1)) begin errors++; $display("FAIL rnd_data idx %0d got %0d last %0b exp %0d", exp_idx, got_data(), bus.out_last_o, exp_d[exp_idx]); end
      bus.out_ready_i = 1'(($urandom_range(0, 2) != 0));
      bus.capture_i   = 1'b0;
      if (bus.out_ready_i) begin
        if (exp_idx == N-1) begin
          drains++;
          exp_idx = 0;
          if (drains < 30 && $urandom_range(0, 1) == 1) begin
            load_random(exp_d);
            bus.capture_i = 1'b1;
          end else begin
            idle_next = 1'b1;
          end
        end else begin
          exp_idx++;
        end
      end
      @(negedge clk);
      bus.capture_i = 1'b0;
      if (idle_next) begin
        checks++; if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL rnd_idle got valid %0b busy %0b exp 0/0", bus.out_valid_o, bus.busy_o); end
        if (drains < 30) begin
          load_random(exp_d);
          bus.capture_i = 1'b1;
          @(negedge clk);
          bus.capture_i = 1'b0;
        end
      end
    end
    bus.out_ready_i = 1'b1;
    checks++; if (drains !== 30) begin errors++; $display("FAIL rnd_timeout got %0d drains exp 30", drains); end
  endtask

  initial begin
    rst = 1'b1;
    bus.capture_i   = 1'b0;
    bus.acc_i       = '0;
    bus.shift_i     = '0;
    bus.relu_en_i   = 1'b0;
    bus.out_ready_i = 1'b1;
    test_reset();
    test_basic_drain();
    test_relu_shift();
    test_backpressure();
    test_overrun_back_to_back();
    test_clamp_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
